// File: rtl/controle_frota.sv
// Enemy fleet controller: tick-driven sweep/descent FSM plus a round-robin shot arbiter.
// All state is on CLOCK_50; reset and reiniciarJogo are synchronous restarts.
//
//   state  | meaning
//   ATIVO  | fleet sweeping horizontally, one step per tick
//   DESCER | edge reached, next tick drops one row and reverses
//   FIM    | wave over (destroyed or arrived), everything frozen
module controle_frota #(
  parameter int NUM_INIMIGOS      = 8,
  parameter int TICK_DIV          = 320000,
  parameter int PASSO_X           = 2,
  parameter int PASSO_Y           = 20,
  parameter int LARGURA           = 33,
  parameter int ESPACO            = 48,
  parameter int X0                = 40,
  parameter int Y0                = 20,
  parameter int X_MAX             = 640,
  parameter int Y_LIMITE          = 400,
  parameter int DISPARO_INTERVALO = 16
) (
  input  logic                    CLOCK_50,
  input  logic                    reset,
  input  logic                    pausa,
  input  logic                    reiniciarJogo,
  input  logic [NUM_INIMIGOS-1:0] vivos,
  input  logic                    bola_livre,
  output logic [9:0]              base_x,
  output logic [9:0]              base_y,
  output logic                    sentidoX,
  output logic                    passo,
  output logic                    disparo,
  output logic [2:0]              disparo_idx,
  output logic                    frota_destruida,
  output logic                    frota_chegou
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = $clog2(DISPARO_INTERVALO + 1);

  localparam logic [1:0] ATIVO  = 2'd0;
  localparam logic [1:0] DESCER = 2'd1;
  localparam logic [1:0] FIM    = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [DW-1:0] cd;
  logic [2:0]    ptr;
  logic [2:0]    esq, dir, alvo, j;
  logic [10:0]   borda_dir, borda_esq, ny;
  logic          tick, alguem, fogo;

  assign tick   = !pausa && (cnt == CW'(TICK_DIV - 1));
  assign alguem = |vivos;
  assign fogo   = !pausa && (state != FIM) && alguem && bola_livre &&
                  (cd == DW'(DISPARO_INTERVALO));

  // Loops run in reverse so the last hit is the first one in search order.
  always_comb begin
    esq  = '0;
    dir  = '0;
    alvo = '0;
    j    = '0;
    for (int i = NUM_INIMIGOS - 1; i >= 0; i--)
      if (vivos[i]) esq = 3'(i);
    for (int i = 0; i < NUM_INIMIGOS; i++)
      if (vivos[i]) dir = 3'(i);
    for (int k = NUM_INIMIGOS; k >= 1; k--) begin
      j = ptr + 3'(k);
      if (vivos[j]) alvo = j;
    end
  end

  // Edge arithmetic is widened to 11 bits so nothing wraps.
  assign borda_dir = {1'b0, base_x} + 11'(dir) * 11'(ESPACO) + 11'(LARGURA + PASSO_X);
  assign borda_esq = {1'b0, base_x} + 11'(esq) * 11'(ESPACO);
  assign ny        = {1'b0, base_y} + 11'(PASSO_Y);

  always_ff @(posedge CLOCK_50) begin
    if (reset || reiniciarJogo) begin
      state           <= ATIVO;
      cnt             <= '0;
      cd              <= '0;
      ptr             <= 3'd7;
      base_x          <= 10'(X0);
      base_y          <= 10'(Y0);
      sentidoX        <= 1'b1;
      passo           <= 1'b0;
      disparo         <= 1'b0;
      disparo_idx     <= '0;
      frota_destruida <= 1'b0;
      frota_chegou    <= 1'b0;
    end else begin
      passo   <= 1'b0;
      disparo <= 1'b0;
      if (!pausa) begin
        cnt <= tick ? '0 : cnt + CW'(1);

        if (fogo) begin
          disparo     <= 1'b1;
          disparo_idx <= alvo;
          ptr         <= alvo;
          cd          <= '0;
        end else if (tick && (cd != DW'(DISPARO_INTERVALO))) begin
          cd <= cd + DW'(1);
        end

        if ((state != FIM) && !alguem) begin
          state           <= FIM;
          frota_destruida <= 1'b1;
        end else if (tick && (state != FIM)) begin
          passo <= 1'b1;
          if (state == ATIVO) begin
            if (sentidoX) begin
              if (borda_dir > 11'(X_MAX)) state <= DESCER;
              else base_x <= base_x + 10'(PASSO_X);
            end else begin
              if (borda_esq < 11'(PASSO_X)) state <= DESCER;
              else base_x <= base_x - 10'(PASSO_X);
            end
          end else begin
            base_y   <= ny[9:0];
            sentidoX <= !sentidoX;
            if (ny >= 11'(Y_LIMITE)) begin
              state        <= FIM;
              frota_chegou <= 1'b1;
            end else begin
              state <= ATIVO;
            end
          end
        end
      end
    end
  end

endmodule
